// File: rtl/lsu_pkg.sv
// lsu_pkg: memory map constants, peripheral slots and region decode
// shared by the load/store unit files.
package lsu_pkg;

  localparam logic [11:0] DMEM_BASE   = 12'h000;
  localparam logic [11:0] DMEM_LIMIT  = 12'h7FF;
  localparam logic [11:0] IO_OUT_BASE = 12'h800;
  localparam logic [11:0] SW_BASE     = 12'h900;

  localparam int HEX0 = 0;
  localparam int HEX1 = 1;
  localparam int HEX2 = 2;
  localparam int HEX3 = 3;
  localparam int HEX4 = 4;
  localparam int HEX5 = 5;
  localparam int HEX6 = 6;
  localparam int HEX7 = 7;
  localparam int LEDR = 8;
  localparam int LEDG = 9;
  localparam int LCD  = 10;
  localparam int NUM_OUT = 11;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_DMEM,
    REG_OUT,
    REG_SW
  } region_e;

  // Byte offset bits never affect the region, so aliases decode alike.
  function automatic region_e decode_region(input logic [11:0] a);
    if (a >= DMEM_BASE && a <= DMEM_LIMIT)
      return REG_DMEM;
    if (a[11:8] == IO_OUT_BASE[11:8])
      return (a[7:4] <= 4'(LCD)) ? REG_OUT : REG_NONE;
    if (a[11:8] == SW_BASE[11:8])
      return REG_SW;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/lsu_mem_io_if.sv
// lsu_mem_io_if: core-side load/store bus of the LSU
// (store enable, address, store data, byte lanes, load data).
interface lsu_mem_io_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic                  st_en;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     st_data;
  logic [DATA_W/8-1:0]   byte_en;
  logic [DATA_W-1:0]     ld_data;

  modport master (
    output st_en, addr, st_data, byte_en,
    input  ld_data
  );

  modport slave (
    input  st_en, addr, st_data, byte_en,
    output ld_data
  );
endinterface

// File: rtl/lsu_dmem.sv
// lsu_dmem: word-organised RAM, byte-lane write enables,
// synchronous write, asynchronous read, no reset.
module lsu_dmem #(
  parameter int DATA_W = 32,
  parameter int WORDS  = 512,
  parameter int AW     = $clog2(WORDS)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       idx,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   rdata
);
  logic [DATA_W-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < DATA_W/8; k++) begin
        if (be[k])
          mem[idx][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  assign rdata = mem[idx];
endmodule

// File: rtl/lsu_mem_io.sv
// lsu_mem_io: load/store unit over data memory, output registers
// and switch input. Define LSU_SW_SYNC_EN to synchronize io_sw.
module lsu_mem_io
  import lsu_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int DMEM_WORDS = 512
) (
  input  logic              clk_i,
  input  logic              rst_i,
  lsu_mem_io_if.slave       bus,
  input  logic [DATA_W-1:0] io_sw,
  output logic [DATA_W-1:0] io_hex0,
  output logic [DATA_W-1:0] io_hex1,
  output logic [DATA_W-1:0] io_hex2,
  output logic [DATA_W-1:0] io_hex3,
  output logic [DATA_W-1:0] io_hex4,
  output logic [DATA_W-1:0] io_hex5,
  output logic [DATA_W-1:0] io_hex6,
  output logic [DATA_W-1:0] io_hex7,
  output logic [DATA_W-1:0] io_ledr,
  output logic [DATA_W-1:0] io_ledg,
  output logic [DATA_W-1:0] io_lcd
);
  localparam int LANES = DATA_W/8;
  localparam int DAW   = $clog2(DMEM_WORDS);

  region_e           region;
  logic [3:0]        slot;
  logic [DATA_W-1:0] dmem_rd;
  logic [DATA_W-1:0] sw_val;
  logic [DATA_W-1:0] out_q [NUM_OUT];
  logic              dmem_we;

  assign region  = decode_region(bus.addr[ADDR_W-1:0]);
  assign slot    = bus.addr[7:4];
  assign dmem_we = bus.st_en && (region == REG_DMEM);

  lsu_dmem #(
    .DATA_W (DATA_W),
    .WORDS  (DMEM_WORDS)
  ) u_dmem (
    .clk   (clk_i),
    .we    (dmem_we),
    .idx   (bus.addr[DAW+1:2]),
    .wdata (bus.st_data),
    .be    (bus.byte_en),
    .rdata (dmem_rd)
  );

  // Reset wins over a simultaneous store to an output register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_OUT; i++)
        out_q[i] <= '0;
    end else if (bus.st_en && region == REG_OUT) begin
      for (int k = 0; k < LANES; k++) begin
        if (bus.byte_en[k])
          out_q[slot][8*k +: 8] <= bus.st_data[8*k +: 8];
      end
    end
  end

`ifdef LSU_SW_SYNC_EN
  logic [DATA_W-1:0] sw_meta;
  logic [DATA_W-1:0] sw_sync;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= io_sw;
      sw_sync <= sw_meta;
    end
  end

  assign sw_val = sw_sync;
`else
  assign sw_val = io_sw;
`endif

  always_comb begin
    bus.ld_data = '0;
    unique case (region)
      REG_DMEM: bus.ld_data = dmem_rd;
      REG_OUT:  bus.ld_data = out_q[slot];
      REG_SW:   bus.ld_data = sw_val;
      default:  bus.ld_data = '0;
    endcase
  end

  assign io_hex0 = out_q[HEX0];
  assign io_hex1 = out_q[HEX1];
  assign io_hex2 = out_q[HEX2];
  assign io_hex3 = out_q[HEX3];
  assign io_hex4 = out_q[HEX4];
  assign io_hex5 = out_q[HEX5];
  assign io_hex6 = out_q[HEX6];
  assign io_hex7 = out_q[HEX7];
  assign io_ledr = out_q[LEDR];
  assign io_ledg = out_q[LEDG];
  assign io_lcd  = out_q[LCD];
endmodule

// File: tb/tb_lsu_mem_io.sv
// tb_lsu_mem_io: directed and random checks of lsu_mem_io
// against a memory-map reference model.
module tb_lsu_mem_io;
  logic        clk = 0;
  logic        rst;
  logic [31:0] sw;
  logic [31:0] obs [11];
  logic [31:0] hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic [31:0] ledr, ledg, lcd;
  int total = 0;
  int bad = 0;

  logic [31:0] m_mem [512];
  logic [3:0]  m_vld [512];
  logic [31:0] m_reg [11];

  lsu_mem_io_if bus ();

  lsu_mem_io dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (bus),
    .io_sw   (sw),
    .io_hex0 (hex0),
    .io_hex1 (hex1),
    .io_hex2 (hex2),
    .io_hex3 (hex3),
    .io_hex4 (hex4),
    .io_hex5 (hex5),
    .io_hex6 (hex6),
    .io_hex7 (hex7),
    .io_ledr (ledr),
    .io_ledg (ledg),
    .io_lcd  (lcd)
  );

  always #5 clk = ~clk;

  always_comb begin
    obs[0] = hex0; obs[1] = hex1; obs[2] = hex2; obs[3] = hex3;
    obs[4] = hex4; obs[5] = hex5; obs[6] = hex6; obs[7] = hex7;
    obs[8] = ledr; obs[9] = ledg; obs[10] = lcd;
  end

  function automatic void model_step(input logic r, input logic s,
      input logic [11:0] a, input logic [31:0] d, input logic [3:0] b);
    int w;
    int n;
    if (s && a < 12'h800) begin
      w = int'(a) / 4;
      for (int k = 0; k < 4; k++)
        if (b[k]) begin
          m_mem[w][8*k +: 8] = d[8*k +: 8];
          m_vld[w][k] = 1'b1;
        end
    end
    if (r) begin
      for (int i = 0; i < 11; i++) m_reg[i] = 0;
    end else if (s && a >= 12'h800 && a < 12'h8B0) begin
      n = (int'(a) - 'h800) / 16;
      for (int k = 0; k < 4; k++)
        if (b[k]) m_reg[n][8*k +: 8] = d[8*k +: 8];
    end
  endfunction

  function automatic logic [31:0] model_ld(input logic [11:0] a,
                                           output logic known);
    known = 1'b1;
    if (a < 12'h800) begin
      known = (m_vld[int'(a) / 4] == 4'hF);
      return m_mem[int'(a) / 4];
    end
    if (a < 12'h8B0) return m_reg[(int'(a) - 'h800) / 16];
    if (a >= 12'h900 && a < 12'hA00) return sw;
    return 0;
  endfunction

  task automatic cycle(input logic r, input logic s, input logic [11:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    @(negedge clk);
    rst = r; bus.st_en = s; bus.addr = a; bus.st_data = d; bus.byte_en = b;
    @(posedge clk);
    model_step(r, s, a, d, b);
    #1;
  endtask

  task automatic test_reset;
    cycle(1, 1, 12'h752, 32'h13579BDF, 4'hF);
    total++;
    if (bus.ld_data !== 32'h13579BDF) begin
      bad++;
      $display("FAIL reset_dmem got=%h exp=%h", bus.ld_data, 32'h13579BDF);
    end
    for (int i = 0; i < 11; i++) begin
      total++;
      if (obs[i] !== 32'h0) begin
        bad++;
        $display("FAIL reset_reg%0d got=%h exp=0", i, obs[i]);
      end
    end
  endtask

  task automatic test_io_store;
    cycle(0, 1, 12'h815, 32'h89ABCDEF, 4'hF);
    total++;
    if (hex1 !== 32'h89ABCDEF || bus.ld_data !== 32'h89ABCDEF) begin
      bad++;
      $display("FAIL hex1_store got=%h ld=%h exp=89abcdef", hex1, bus.ld_data);
    end
    cycle(0, 1, 12'h8A0, 32'h89ABCDEF, 4'hF);
    total++;
    if (lcd !== 32'h89ABCDEF || bus.ld_data !== 32'h89ABCDEF) begin
      bad++;
      $display("FAIL lcd_store got=%h ld=%h exp=89abcdef", lcd, bus.ld_data);
    end
  endtask

  task automatic test_all_slots;
    for (int n = 0; n < 11; n++) begin
      cycle(0, 1, 12'(12'h800 + 16*n), 32'h01234567 + 32'(n), 4'hF);
      total++;
      if (bus.ld_data !== 32'h01234567 + 32'(n)) begin
        bad++;
        $display("FAIL slot%0d_ld got=%h exp=%h", n, bus.ld_data,
                 32'h01234567 + 32'(n));
      end
      for (int i = 0; i < 11; i++) begin
        total++;
        if (obs[i] !== m_reg[i]) begin
          bad++;
          $display("FAIL slot%0d_reg%0d got=%h exp=%h", n, i, obs[i], m_reg[i]);
        end
      end
    end
  endtask

  task automatic test_switch;
    logic k;
    sw = 32'd3;
    cycle(0, 0, 12'h000, 0, 4'h0);
    cycle(0, 0, 12'h000, 0, 4'h0);
    cycle(0, 1, 12'h900, 32'h01234567, 4'hF);
    total++;
    if (bus.ld_data !== 32'd3) begin
      bad++;
      $display("FAIL sw_read got=%h exp=3", bus.ld_data);
    end
    for (int i = 0; i < 11; i++) begin
      total++;
      if (obs[i] !== m_reg[i]) begin
        bad++;
        $display("FAIL sw_noreg%0d got=%h exp=%h", i, obs[i], m_reg[i]);
      end
    end
    sw = 32'd5;
    cycle(0, 0, 12'h912, 0, 4'h0);
    cycle(0, 0, 12'h912, 0, 4'h0);
    cycle(0, 0, 12'h912, 0, 4'h0);
    total++;
    if (bus.ld_data !== 32'd5) begin
      bad++;
      $display("FAIL sw_read5 got=%h exp=5", bus.ld_data);
    end
    cycle(0, 0, 12'h752, 0, 4'h0);
    total++;
    if (bus.ld_data !== model_ld(12'h752, k)) begin
      bad++;
      $display("FAIL sw_nomem got=%h exp=%h", bus.ld_data, model_ld(12'h752, k));
    end
  endtask

  task automatic test_reset_regs;
    cycle(0, 1, 12'h7A8, 32'h1, 4'hF);
    cycle(0, 1, 12'h830, 32'hDEADBEEF, 4'hF);
    cycle(1, 0, 12'h7A8, 0, 4'h0);
    for (int i = 0; i < 11; i++) begin
      total++;
      if (obs[i] !== 32'h0) begin
        bad++;
        $display("FAIL rst2_reg%0d got=%h exp=0", i, obs[i]);
      end
    end
    total++;
    if (bus.ld_data !== 32'h1) begin
      bad++;
      $display("FAIL rst2_mem got=%h exp=1", bus.ld_data);
    end
    cycle(1, 1, 12'h840, 32'hCAFEF00D, 4'hF);
    total++;
    if (hex4 !== 32'h0) begin
      bad++;
      $display("FAIL rst_over_store got=%h exp=0", hex4);
    end
    cycle(0, 0, 12'h7AB, 0, 4'h0);
    total++;
    if (bus.ld_data !== 32'h1) begin
      bad++;
      $display("FAIL alias got=%h exp=1", bus.ld_data);
    end
  endtask

  task automatic test_byte_en;
    cycle(0, 1, 12'h810, 32'h13579BDF, 4'hF);
    cycle(0, 1, 12'h810, 32'hFFFFFFFF, 4'b0011);
    total++;
    if (hex1 !== 32'h1357FFFF) begin
      bad++;
      $display("FAIL be0011 got=%h exp=1357ffff", hex1);
    end
    cycle(0, 1, 12'h810, 32'h0, 4'b0001);
    total++;
    if (hex1 !== 32'h1357FF00) begin
      bad++;
      $display("FAIL be0001 got=%h exp=1357ff00", hex1);
    end
    cycle(0, 1, 12'h810, 32'hAAAAAAAA, 4'b0000);
    total++;
    if (hex1 !== 32'h1357FF00) begin
      bad++;
      $display("FAIL be0000 got=%h exp=1357ff00", hex1);
    end
  endtask

  task automatic test_unmapped;
    cycle(0, 1, 12'h8B4, 32'h55AA55AA, 4'hF);
    total++;
    if (bus.ld_data !== 32'h0) begin
      bad++;
      $display("FAIL unmap_8b got=%h exp=0", bus.ld_data);
    end
    cycle(0, 1, 12'hA40, 32'h55AA55AA, 4'hF);
    total++;
    if (bus.ld_data !== 32'h0) begin
      bad++;
      $display("FAIL unmap_a4 got=%h exp=0", bus.ld_data);
    end
    for (int i = 0; i < 11; i++) begin
      total++;
      if (obs[i] !== m_reg[i]) begin
        bad++;
        $display("FAIL unmap_reg%0d got=%h exp=%h", i, obs[i], m_reg[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [11:0] a;
    logic [31:0] e;
    logic        k;
    sw = 0;
    cycle(0, 0, 12'h000, 0, 4'h0);
    cycle(0, 0, 12'h000, 0, 4'h0);
    cycle(0, 0, 12'h000, 0, 4'h0);
    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 3))
        0: a = 12'($urandom_range(0, 63));
        1: a = 12'h800 + 12'($urandom_range(0, 255));
        2: a = 12'h900 + 12'($urandom_range(0, 255));
        default: a = 12'($urandom_range('hA00, 'hFFF));
      endcase
      cycle(($urandom_range(0, 31) == 0), 1'($urandom), a, $urandom,
            4'($urandom));
      e = model_ld(a, k);
      if (k) begin
        total++;
        if (bus.ld_data !== e) begin
          bad++;
          $display("FAIL rnd%0d_ld a=%h got=%h exp=%h", t, a, bus.ld_data, e);
        end
      end
      for (int i = 0; i < 11; i++) begin
        total++;
        if (obs[i] !== m_reg[i]) begin
          bad++;
          $display("FAIL rnd%0d_reg%0d got=%h exp=%h", t, i, obs[i], m_reg[i]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      m_mem[i] = 'x;
      m_vld[i] = 0;
    end
    for (int i = 0; i < 11; i++) m_reg[i] = 0;
    rst = 0; sw = 0;
    bus.st_en = 0; bus.addr = 0; bus.st_data = 0; bus.byte_en = 0;
    test_reset();
    test_io_store();
    test_all_slots();
    test_switch();
    test_reset_regs();
    test_byte_en();
    test_unmapped();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
